ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_pkg.sv | 65 ++++++
 rtl/ex_muldiv_sign_fix.sv | 95 +++++++++
 rtl/ex_muldiv.sv | 130 +++++++++++++
 tb/tb_ex_muldiv.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the EX-stage iterative multiply/divide unit.
package ex_muldiv_pkg;

   typedef enum logic [3:0] {
      MUL    = 4'd0,
      MULH   = 4'd1,
      MULHSU = 4'd2,
      MULHU  = 4'd3,
      DIV    = 4'd4,
      DIVU   = 4'd5,
      REM    = 4'd6,
      REMU   = 4'd7,
      MULW   = 4'd8,
      DIVW   = 4'd9,
      DIVUW  = 4'd10,
      REMW   = 4'd11,
      REMUW  = 4'd12
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [6:0] ITER64 = 7'd64;
   localparam logic [6:0] ITER32 = 7'd32;

   // 32-bit operations working on src[31:0] with a sign-extended result
   function automatic logic isWordOp(muldiv_op_t op);
      case (op)
         MULW, DIVW, DIVUW, REMW, REMUW: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

   function automatic logic isDivOp(muldiv_op_t op);
      case (op)
         DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW: return 1'b1;
         default:                                        return 1'b0;
      endcase
   endfunction

   function automatic logic isRemOp(muldiv_op_t op);
      case (op)
         REM, REMU, REMW, REMUW: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

   function automatic logic isSignedA(muldiv_op_t op);
      case (op)
         MUL, MULH, MULHSU, DIV, REM, MULW, DIVW, REMW: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

   function automatic logic isSignedB(muldiv_op_t op);
      case (op)
         MUL, MULH, DIV, REM, MULW, DIVW, REMW: return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ex_muldiv_sign_fix.sv
// Sign/magnitude conversion around the unsigned iterative core, plus the
// single-cycle special cases (divide by zero, signed overflow, illegal op).
module muldiv_sign_fix
   import ex_muldiv_pkg::*;
(
   input  muldiv_op_t   i_preOp,
   input  logic [63:0]  i_srcA,
   input  logic [63:0]  i_srcB,
   output logic [63:0]  o_magA,
   output logic [63:0]  o_magB,
   output logic         o_negQ,
   output logic         o_negR,
   output logic         o_special,
   output logic [63:0]  o_specialResult,
   input  muldiv_op_t   i_postOp,
   input  logic         i_postNegQ,
   input  logic         i_postNegR,
   input  logic [127:0] i_acc,
   output logic [63:0]  o_result
);

   logic        w_word;
   logic        w_aNeg;
   logic        w_bNeg;
   logic        w_bZero;
   logic        w_ovf;
   logic        w_legal;
   logic [31:0] w_a32Neg;
   logic [31:0] w_b32Neg;
   logic [63:0] w_sextA;

   // Operand magnitudes, result signs and the cases that skip iteration
   always_comb begin
      w_word   = isWordOp(i_preOp);
      w_legal  = (i_preOp <= REMUW);
      w_aNeg   = isSignedA(i_preOp) & (w_word ? i_srcA[31] : i_srcA[63]);
      w_bNeg   = isSignedB(i_preOp) & (w_word ? i_srcB[31] : i_srcB[63]);
      w_a32Neg = 32'd0 - i_srcA[31:0];
      w_b32Neg = 32'd0 - i_srcB[31:0];
      w_sextA  = w_word ? {{32{i_srcA[31]}}, i_srcA[31:0]} : i_srcA;
      if (w_word) begin
         o_magA = {32'd0, w_aNeg ? w_a32Neg : i_srcA[31:0]};
         o_magB = {32'd0, w_bNeg ? w_b32Neg : i_srcB[31:0]};
         w_bZero = (i_srcB[31:0] == 32'd0);
         w_ovf   = (i_srcA[31:0] == 32'h8000_0000) && (i_srcB[31:0] == 32'hFFFF_FFFF);
      end else begin
         o_magA = w_aNeg ? (64'd0 - i_srcA) : i_srcA;
         o_magB = w_bNeg ? (64'd0 - i_srcB) : i_srcB;
         w_bZero = (i_srcB == 64'd0);
         w_ovf   = (i_srcA == 64'h8000_0000_0000_0000) && (i_srcB == 64'hFFFF_FFFF_FFFF_FFFF);
      end
      w_ovf  = w_ovf & isDivOp(i_preOp) & isSignedA(i_preOp);
      o_negQ = w_aNeg ^ w_bNeg;
      o_negR = w_aNeg;
      o_special       = 1'b0;
      o_specialResult = 64'd0;
      if (!w_legal) begin
         o_special = 1'b1;
      end else if (isDivOp(i_preOp) && w_bZero) begin
         o_special       = 1'b1;
         o_specialResult = isRemOp(i_preOp) ? w_sextA : 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (w_ovf) begin
         o_special       = 1'b1;
         o_specialResult = isRemOp(i_preOp) ? 64'd0 : w_sextA;
      end
   end

   logic [127:0] w_prodS;
   logic [31:0]  w_mulw32;
   logic [63:0]  w_q64S;
   logic [63:0]  w_r64S;
   logic [31:0]  w_q32S;
   logic [31:0]  w_r32S;

   // Re-apply signs to the final accumulator and pick the requested slice
   always_comb begin
      w_prodS  = i_postNegQ ? (128'd0 - i_acc) : i_acc;
      w_mulw32 = i_postNegQ ? (32'd0 - i_acc[63:32]) : i_acc[63:32];
      w_q64S   = i_postNegQ ? (64'd0 - i_acc[63:0]) : i_acc[63:0];
      w_r64S   = i_postNegR ? (64'd0 - i_acc[127:64]) : i_acc[127:64];
      w_q32S   = i_postNegQ ? (32'd0 - i_acc[31:0]) : i_acc[31:0];
      w_r32S   = i_postNegR ? (32'd0 - i_acc[95:64]) : i_acc[95:64];
      case (i_postOp)
         MUL:                 o_result = w_prodS[63:0];
         MULH, MULHSU, MULHU: o_result = w_prodS[127:64];
         MULW:                o_result = {{32{w_mulw32[31]}}, w_mulw32};
         DIV, DIVU:           o_result = w_q64S;
         REM, REMU:           o_result = w_r64S;
         DIVW, DIVUW:         o_result = {{32{w_q32S[31]}}, w_q32S};
         REMW, REMUW:         o_result = {{32{w_r32S[31]}}, w_r32S};
         default:             o_result = 64'd0;
      endcase
   end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage: one bit per cycle
// shift-add multiply and restoring divide sharing a 128-bit accumulator.
module ex_muldiv
   import ex_muldiv_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         start,
   input  muldiv_op_t   op,
   input  logic [63:0]  src_a,
   input  logic [63:0]  src_b,
   output logic         busy,
   output logic         done,
   output logic [63:0]  result
);

   state_t       r_state;
   logic [6:0]   r_cnt;
   logic [127:0] r_acc;
   logic [63:0]  r_b;
   muldiv_op_t   r_op;
   logic         r_negQ;
   logic         r_negR;
   logic [63:0]  r_result;

   logic [63:0]  w_magA;
   logic [63:0]  w_magB;
   logic         w_negQ;
   logic         w_negR;
   logic         w_special;
   logic [63:0]  w_specialResult;
   logic [63:0]  w_result;
   logic [127:0] w_accNext;
   logic [64:0]  w_mulSum;
   logic [64:0]  w_divShift;
   logic [63:0]  w_divDiff;
   logic         w_divFits;

   muldiv_sign_fix u_signFix (
      .i_preOp         (op),
      .i_srcA          (src_a),
      .i_srcB          (src_b),
      .o_magA          (w_magA),
      .o_magB          (w_magB),
      .o_negQ          (w_negQ),
      .o_negR          (w_negR),
      .o_special       (w_special),
      .o_specialResult (w_specialResult),
      .i_postOp        (r_op),
      .i_postNegQ      (r_negQ),
      .i_postNegR      (r_negR),
      .i_acc           (w_accNext),
      .o_result        (w_result)
   );

   // One iteration: multiply adds r_b into the top half and shifts right;
   // divide shifts the next dividend bit into the remainder and subtracts if it fits
   always_comb begin
      w_mulSum   = {1'b0, r_acc[127:64]} + (r_acc[0] ? {1'b0, r_b} : 65'd0);
      w_divShift = {r_acc[127:64], r_acc[63]};
      w_divFits  = (w_divShift >= {1'b0, r_b});
      w_divDiff  = w_divShift[63:0] - r_b;
      if (isDivOp(r_op)) begin
         w_accNext = {(w_divFits ? w_divDiff : w_divShift[63:0]), r_acc[62:0], w_divFits};
      end else begin
         w_accNext = {w_mulSum, r_acc[63:1]};
      end
   end

   // Control FSM and datapath registers; flush outranks start and expiry
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= 7'd0;
         r_acc    <= 128'd0;
         r_b      <= 64'd0;
         r_op     <= MUL;
         r_negQ   <= 1'b0;
         r_negR   <= 1'b0;
         r_result <= 64'd0;
      end else if (flush) begin
         r_state <= IDLE;
         r_cnt   <= 7'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_op   <= op;
                  r_negQ <= w_negQ;
                  r_negR <= w_negR;
                  if (w_special) begin
                     r_result <= w_specialResult;
                     r_state  <= DONE;
                  end else begin
                     r_cnt <= isWordOp(op) ? ITER32 : ITER64;
                     if (isDivOp(op)) begin
                        r_b   <= w_magB;
                        r_acc <= {64'd0, (isWordOp(op) ? {w_magA[31:0], 32'd0} : w_magA)};
                     end else begin
                        r_b   <= w_magA;
                        r_acc <= {64'd0, w_magB};
                     end
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               r_acc <= w_accNext;
               r_cnt <= r_cnt - 7'd1;
               if (r_cnt == 7'd1) begin
                  r_result <= w_result;
                  r_state  <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy   = (r_state != IDLE);
   assign done   = (r_state == DONE);
   assign result = r_result;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected results and
// latencies, a monitor pops and compares on every done pulse.
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        start;
   muldiv_op_t  op;
   logic [63:0] src_a;
   logic [63:0] src_b;
   logic        busy;
   logic        done;
   logic [63:0] result;

   typedef struct {
      string       name;
      logic [63:0] expRes;
      int          expLat;
      int          startEdge;
   } exp_t;

   exp_t sbQueue[$];
   int   checks   = 0;
   int   errors   = 0;
   int   cycCount = 0;

   ex_muldiv dut (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .start  (start),
      .op     (op),
      .src_a  (src_a),
      .src_b  (src_b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   // Free-running clock and rising-edge counter used for latency measurement
   always #5 clk = ~clk;
   always @(posedge clk) cycCount <= cycCount + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   initial begin
      exp_t e;
      int   lat;
      forever begin
         @(posedge clk);
         #1;
         if (done) begin
            if (sbQueue.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpectedDone result=%h required=no done", result);
            end else begin
               e   = sbQueue.pop_front();
               lat = cycCount - e.startEdge + 1;
               checkOutput({e.name, "_result"}, result, e.expRes);
               checkOutput({e.name, "_latency"}, 64'(lat), 64'(e.expLat));
            end
         end
      end
   end

   task automatic waitIdle(input string name);
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_timeout busy=1 required=0", name);
      end
   endtask

   task automatic applyStimulus(input string name, input muldiv_op_t o, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] expRes, input int expLat,
                                input bit pokeBusy);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      e.name      = name;
      e.expRes    = expRes;
      e.expLat    = expLat;
      e.startEdge = cycCount + 1;
      sbQueue.push_back(e);
      @(negedge clk);
      start = 1'b0;
      op    = MULHU;
      src_a = {$urandom(), $urandom()};
      src_b = {$urandom(), $urandom()};
      if (pokeBusy) begin
         start = 1'b1;
         op    = MUL;
         @(negedge clk);
         start = 1'b0;
      end
      waitIdle(name);
      @(negedge clk);
      checkOutput({name, "_held"}, result, expRes);
   endtask

   // Watchdog so the run always ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog cycles=%0d required=finish", cycCount);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence
   initial begin
      reset = 1'b1;
      flush = 1'b0;
      start = 1'b0;
      op    = MUL;
      src_a = 64'd0;
      src_b = 64'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checkOutput("reset_busy",   64'(busy), 64'd0);
      checkOutput("reset_done",   64'(done), 64'd0);
      checkOutput("reset_result", result,    64'd0);

      applyStimulus("mul_7x-3",     MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
      applyStimulus("div_ovf",      DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 0);
      applyStimulus("rem_ovf",      REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
      applyStimulus("divu_by0",     DIVU,   64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
      applyStimulus("remu_by0",     REMU,   64'd100, 64'd0, 64'd100, 1, 0);
      applyStimulus("divw_-7/2",    DIVW,   64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
      applyStimulus("mulhu_ones",   MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
      applyStimulus("mulh_ones",    MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65, 0);
      applyStimulus("mulh_-2x3",    MULH,   64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
      applyStimulus("mulhsu_ones",  MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
      applyStimulus("mul_big",      MUL,    64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 64'h0000_0002_0000_0001, 65, 0);
      applyStimulus("div_-20/6",    DIV,    64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1);
      applyStimulus("rem_-20%6",    REM,    64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
      applyStimulus("divu_1000/7",  DIVU,   64'd1000, 64'd7, 64'd142, 65, 0);
      applyStimulus("remu_1000%7",  REMU,   64'd1000, 64'd7, 64'd6, 65, 0);
      applyStimulus("mulw_max_x2",  MULW,   64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
      applyStimulus("divuw_sext",   DIVUW,  64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33, 0);
      applyStimulus("remuw_hi_ign", REMUW,  64'h0000_0123_0000_0005, 64'd3, 64'd2, 33, 0);
      applyStimulus("divw_ovf",     DIVW,   64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
      applyStimulus("remw_by0",     REMW,   64'h0000_0000_FFFF_FFF0, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFF0, 1, 0);
      applyStimulus("illegal_13",   muldiv_op_t'(4'd13), 64'd55, 64'd3, 64'd0, 1, 0);

      // Flush in the tenth CALC cycle: no done, idle on the next cycle
      @(negedge clk);
      start = 1'b1;
      op    = MUL;
      src_a = 64'd9;
      src_b = 64'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checkOutput("flush_busy", 64'(busy), 64'd0);
      repeat (5) @(negedge clk);
      applyStimulus("remw_-9%4", REMW, 64'hFFFF_FFFF_FFFF_FFF7, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);

      // Reset in the middle of an operation aborts it and clears the result
      @(negedge clk);
      start = 1'b1;
      op    = DIVU;
      src_a = 64'd1000;
      src_b = 64'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("midReset_busy",   64'(busy), 64'd0);
      checkOutput("midReset_result", result,    64'd0);
      repeat (70) @(negedge clk);

      applyStimulus("div_after_rst", DIV, 64'd49, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 65, 0);

      begin
         int n = 0;
         while (sbQueue.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      checkOutput("scoreboardDrained", 64'(sbQueue.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
